// File: rtl/mont_pkg.sv
// -----------------------------------------------------------------------------
// mont_pkg
// Shared types and helpers for the parametrised Montgomery multiplier.
//   state_t      : FSM state encoding (IDLE, LOOP, SUB, DONE), 2 bits
//   FINAL_SUB_EN : 1 when the build defines MONT_FINAL_SUB_EN (final
//                  conditional subtraction present), 0 otherwise
//   cnt_width()  : iteration counter width for a given operand width
// Configuration macro: MONT_FINAL_SUB_EN
// -----------------------------------------------------------------------------
package mont_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOOP = 2'd1,
      SUB  = 2'd2,
      DONE = 2'd3
   } state_t;

`ifdef MONT_FINAL_SUB_EN
   localparam bit FINAL_SUB_EN = 1'b1;
`else
   localparam bit FINAL_SUB_EN = 1'b0;
`endif

   // One extra bit so the counter can represent WIDTH itself.
   function automatic int cnt_width(input int width);
      return $clog2(width) + 1;
   endfunction

endpackage

// File: rtl/mont_iter_step.sv
// -----------------------------------------------------------------------------
// mont_iter_step
// One radix-2 Montgomery iteration, purely combinational:
//   t      = c + (a_bit ? b : 0)
//   c_next = (t + (t[0] ? m : 0)) >> 1
// Kept separate so the WIDTH+2-bit adder chain can be retimed and
// equivalence-checked on its own.
// Ports:
//   c      in  WIDTH+1  current accumulator (c < 2m)
//   b      in  WIDTH    multiplicand (b < m)
//   m      in  WIDTH    odd modulus
//   a_bit  in  1        current multiplier bit
//   c_next out WIDTH+1  next accumulator (stays < 2m)
// -----------------------------------------------------------------------------
module mont_iter_step #(
   parameter int WIDTH = 512
) (
   input  logic [WIDTH:0]   c,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] m,
   input  logic             a_bit,
   output logic [WIDTH:0]   c_next
);

   // c < 2m and b < m give t < 3m, so t + m < 4m fits in WIDTH+2 bits.
   logic [WIDTH+1:0] t;
   logic [WIDTH+1:0] u;
   logic             q;
   logic             unused_lsb;

   assign t = {1'b0, c} + (a_bit ? {2'b00, b} : '0);
   assign q = t[0];
   assign u = t + (q ? {2'b00, m} : '0);

   // Adding m (odd) exactly when t is odd makes u even, so the dropped
   // bit is always zero and the shift is an exact division by two.
   assign unused_lsb = u[0];
   assign c_next     = u[WIDTH+1:1];

endmodule

// File: rtl/mont_mul_param.sv
// -----------------------------------------------------------------------------
// mont_mul_param
// Radix-2 Montgomery modular multiplier: c = a * b * 2^-WIDTH mod m, one full
// iteration per clock, start/done handshake.
// Configuration macro: MONT_FINAL_SUB_EN
//   defined   : a final compare/subtract cycle gives 0 <= c < m,
//               latency WIDTH+1 edges after the accepting edge
//   undefined : raw result 0 <= c < 2m, congruent to a*b*2^-WIDTH mod m,
//               latency WIDTH edges
// Ports:
//   clk     in  1        clock
//   resetn  in  1        synchronous, active-low reset
//   start   in  1        request, sampled only in IDLE
//   a       in  WIDTH    multiplier operand (a < m)
//   b       in  WIDTH    multiplicand operand (b < m)
//   m       in  WIDTH    odd modulus
//   busy    out 1        high in LOOP and SUB
//   done    out 1        one-cycle pulse, c valid
//   c       out WIDTH+1  result, held until the next accepted start
// -----------------------------------------------------------------------------
module mont_mul_param
   import mont_pkg::*;
#(
   parameter int WIDTH = 512
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] m,
   output logic             busy,
   output logic             done,
   output logic [WIDTH:0]   c
);

   localparam int CNT_W = cnt_width(WIDTH);

   state_t           state;
   state_t           state_nxt;

   logic [WIDTH-1:0] a_sh;      // multiplier, shifted right each iteration
   logic [WIDTH-1:0] b_reg;
   logic [WIDTH-1:0] m_reg;
   logic [WIDTH:0]   acc;
   logic [WIDTH:0]   acc_next;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH:0]   c_reg;

   logic             last_iter;
   logic             res_load;  // c_reg captures the final value this cycle
   logic [WIDTH:0]   res_val;

   assign last_iter = (cnt == CNT_W'(WIDTH - 1));

   mont_iter_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .c      (acc),
      .b      (b_reg),
      .m      (m_reg),
      .a_bit  (a_sh[0]),
      .c_next (acc_next)
   );

`ifdef MONT_FINAL_SUB_EN
   // Single compare/subtract: the borrow of acc - m is the acc < m flag.
   logic [WIDTH+1:0] diff;

   assign diff     = {1'b0, acc} - {2'b00, m_reg};
   assign res_val  = diff[WIDTH+1] ? acc : diff[WIDTH:0];
   assign res_load = (state == SUB);
`else
   // No reduction: the last iteration's output goes straight to c.
   assign res_val  = acc_next;
   assign res_load = (state == LOOP) && last_iter;
`endif

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of process order.
      if (!resetn) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      // NOTE: default first; any path that skips an assignment would
      // otherwise infer a latch.
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = LOOP;
         LOOP:    if (last_iter) state_nxt = FINAL_SUB_EN ? SUB : DONE;
         SUB:     state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state)
         LOOP, SUB: busy = 1'b1;
         DONE:      done = 1'b1;
         default:   ;
      endcase
   end

   // ----------------------------------------------------------- datapath
   // NOTE: the operand registers have no reset; they are always loaded on
   // acceptance before they are read, so a reset would only cost area.
   always_ff @(posedge clk) begin
      if (state == IDLE && start) begin
         a_sh  <= a;
         b_reg <= b;
         m_reg <= m;
      end else if (state == LOOP) begin
         a_sh  <= a_sh >> 1;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         acc   <= '0;
         cnt   <= '0;
         c_reg <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  acc <= '0;
                  cnt <= '0;
               end
            end
            LOOP: begin
               acc <= acc_next;
               cnt <= cnt + CNT_W'(1);
            end
            SUB:     acc <= res_val;
            default: ;
         endcase
         // c is captured on the edge entering DONE, so it is already valid
         // while done is high and holds until the next result.
         if (res_load) c_reg <= res_val;
      end
   end

   assign c = c_reg;

endmodule
